// File: rtl/buffer_reader_if.sv
// FIFO read-side and presentation bus between a buffer and buffer_reader.
// master is the reader; slave is the FIFO/consumer side.
interface buffer_reader_if;
    logic        buf_empty;
    logic [15:0] buf_data;
    logic [2:0]  prog;
    logic        flush;
    logic        rd_en;
    logic [15:0] data_2;
    logic        data_2_valid;
    logic        parity;
    logic [7:0]  word_cnt;

    modport master (
        input  buf_empty, buf_data, prog, flush,
        output rd_en, data_2, data_2_valid, parity, word_cnt
    );

    modport slave (
        output buf_empty, buf_data, prog, flush,
        input  rd_en, data_2, data_2_valid, parity, word_cnt
    );
endinterface

// File: rtl/buffer_reader.sv
// Pops one word at a time from a FIFO and presents it for 2^prog cycles,
// or discards it while flush is high.
module buffer_reader (
    input  logic              clk,
    input  logic              rst,
    buffer_reader_if.master   bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOAD, S_HOLD} state_t;

    state_t      r_state;
    logic        r_rd_en;
    logic [15:0] r_data;
    logic        r_valid;
    logic        r_parity;
    logic [7:0]  r_word_cnt;
    logic [7:0]  r_dwell;

    assign bus.rd_en        = r_rd_en;
    assign bus.data_2       = r_data;
    assign bus.data_2_valid = r_valid;
    assign bus.parity       = r_parity;
    assign bus.word_cnt     = r_word_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rd_en    <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_parity   <= 1'b0;
            r_word_cnt <= '0;
            r_dwell    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.buf_empty) begin
                        r_rd_en <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_rd_en <= 1'b0;
                    end
                end
                S_REQ: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (bus.flush) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_data     <= bus.buf_data;
                        r_parity   <= ^bus.buf_data;
                        r_valid    <= 1'b1;
                        // prog is latched into the dwell count here only
                        r_dwell    <= 8'd1 << bus.prog;
                        r_word_cnt <= r_word_cnt + 8'd1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.flush || r_dwell <= 8'd1) begin
                        r_valid <= 1'b0;
                        r_dwell <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_dwell <= r_dwell - 8'd1;
                    end
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader: behavioural FIFO, negedge monitor and
// hand-computed expectations for each scenario.
module tb_buffer_reader;

    logic clk;
    logic rst;
    buffer_reader_if bif ();

    buffer_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data visible the cycle after the edge that samples rd_en=1
    logic [15:0] mem [0:511];
    int wr_ptr;
    int rd_ptr;
    assign bif.buf_empty = (wr_ptr == rd_ptr);

    initial begin
        rd_ptr       = 0;
        bif.buf_data = '0;
    end

    always @(posedge clk) begin
        if (bif.rd_en && (wr_ptr != rd_ptr)) begin
            bif.buf_data <= mem[rd_ptr % 512];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // monitor statistics, sampled on the falling edge
    logic mon_clear;
    int cyc, underflow;
    int rd_pulses, rd_run, rd_max_run, rd_last, rd_interval;
    logic rd_prev;
    int v_run, v_runs, v_last_run, v_max_run, v_min_run, v_gap, v_min_gap;
    logic v_par_or;

    initial begin
        cyc = 0; underflow = 0;
        rd_pulses = 0; rd_run = 0; rd_max_run = 0; rd_last = -1; rd_interval = 0; rd_prev = 1'b0;
        v_run = 0; v_runs = 0; v_last_run = 0; v_max_run = 0; v_min_run = 999;
        v_gap = 0; v_min_gap = 999; v_par_or = 1'b0;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst && bif.rd_en && bif.buf_empty)
            underflow <= underflow + 1;
        if (mon_clear) begin
            rd_pulses <= 0; rd_run <= 0; rd_max_run <= 0; rd_last <= -1; rd_interval <= 0;
            rd_prev <= bif.rd_en;
            v_run <= 0; v_runs <= 0; v_last_run <= 0; v_max_run <= 0; v_min_run <= 999;
            v_gap <= 0; v_min_gap <= 999; v_par_or <= 1'b0;
        end else begin
            if (bif.rd_en) begin
                rd_run <= rd_run + 1;
                if (rd_run + 1 > rd_max_run) rd_max_run <= rd_run + 1;
                if (!rd_prev) begin
                    rd_pulses <= rd_pulses + 1;
                    if (rd_last >= 0) rd_interval <= cyc - rd_last;
                    rd_last <= cyc;
                end
            end else begin
                rd_run <= 0;
            end
            rd_prev <= bif.rd_en;
            if (bif.data_2_valid) begin
                v_run    <= v_run + 1;
                v_par_or <= v_par_or | bif.parity;
                if (v_run == 0 && v_runs > 0 && v_gap < v_min_gap) v_min_gap <= v_gap;
                v_gap <= 0;
            end else begin
                v_gap <= v_gap + 1;
                if (v_run > 0) begin
                    v_runs     <= v_runs + 1;
                    v_last_run <= v_run;
                    if (v_run > v_max_run) v_max_run <= v_run;
                    if (v_run < v_min_run) v_min_run <= v_run;
                end
                v_run <= 0;
            end
        end
    end

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr % 512] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_mon();
        mon_clear = 1'b1;
        @(negedge clk);
        #1 mon_clear = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        tick();
        tick();
        #3 rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0;
        wr_ptr = 0; mon_clear = 1'b0;
        rst = 1'b0; bif.prog = 3'd0; bif.flush = 1'b0;
        #12;
        check("reset_rd_en",  {31'd0, bif.rd_en},        32'd0);
        check("reset_valid",  {31'd0, bif.data_2_valid}, 32'd0);
        check("reset_data",   {16'd0, bif.data_2},       32'd0);
        check("reset_parity", {31'd0, bif.parity},       32'd0);
        check("reset_cnt",    {24'd0, bif.word_cnt},     32'd0);
        #11 rst = 1'b1;
        tick();
        tick();
        check("idle_empty_no_rd", {31'd0, bif.rd_en}, 32'd0);

        // prog=0, single word, 3-edge latency
        push(16'h0001);
        tick();
        check("s1_rd_en_e0",   {31'd0, bif.rd_en},        32'd1);
        check("s1_valid_e0",   {31'd0, bif.data_2_valid}, 32'd0);
        tick();
        check("s1_rd_en_e1",   {31'd0, bif.rd_en},        32'd0);
        check("s1_valid_e1",   {31'd0, bif.data_2_valid}, 32'd0);
        tick();
        check("s1_valid_e2",   {31'd0, bif.data_2_valid}, 32'd1);
        check("s1_data",       {16'd0, bif.data_2},       32'h0001);
        check("s1_parity",     {31'd0, bif.parity},       32'd1);
        check("s1_cnt",        {24'd0, bif.word_cnt},     32'd1);
        tick();
        check("s1_valid_e3",   {31'd0, bif.data_2_valid}, 32'd0);

        // prog=3, two words back to back
        do_reset();
        bif.prog = 3'd3;
        clear_mon();
        push(16'h00FF);
        push(16'h0003);
        for (int i = 0; i < 100 && v_runs < 2; i++) tick();
        tick();
        check("s2_runs",      v_runs,      32'd2);
        check("s2_max_run",   v_max_run,   32'd8);
        check("s2_min_run",   v_min_run,   32'd8);
        check("s2_gap_ge1",   {31'd0, (v_min_gap >= 1 && v_min_gap < 999)}, 32'd1);
        check("s2_rd_pulses", rd_pulses,   32'd2);
        check("s2_rd_period", rd_interval, 32'd11);
        check("s2_rd_width",  rd_max_run,  32'd1);
        check("s2_parity_any",{31'd0, v_par_or},         32'd0);
        check("s2_data",      {16'd0, bif.data_2},       32'h0003);
        check("s2_cnt",       {24'd0, bif.word_cnt},     32'd2);

        // flush discards four queued words
        bif.flush = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) push(16'h5A00 + 16'(i));
        for (int i = 0; i < 60 && rd_ptr != wr_ptr; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        check("s3_rd_pulses", rd_pulses,  32'd4);
        check("s3_rd_width",  rd_max_run, 32'd1);
        check("s3_no_valid",  v_runs + v_run, 32'd0);
        check("s3_data",      {16'd0, bif.data_2},   32'h0003);
        check("s3_cnt",       {24'd0, bif.word_cnt}, 32'd2);
        bif.flush = 1'b0;

        // prog change during hold does not alter current dwell
        bif.prog = 3'd2;
        clear_mon();
        push(16'h8000);
        for (int i = 0; i < 20 && !bif.data_2_valid; i++) tick();
        bif.prog = 3'd7;
        for (int i = 0; i < 40 && v_runs < 1; i++) tick();
        check("s2b_run",    v_last_run, 32'd4);
        check("s2b_parity", {31'd0, bif.parity},   32'd1);
        check("s2b_cnt",    {24'd0, bif.word_cnt}, 32'd3);

        // prog=7, flush at hold cycle 10, then next word
        push(16'hABCD);
        push(16'h1234);
        for (int i = 0; i < 20 && !bif.data_2_valid; i++) tick();
        for (int i = 0; i < 9; i++) tick();
        check("s4_valid_hold9", {31'd0, bif.data_2_valid}, 32'd1);
        bif.flush = 1'b1;
        tick();
        bif.flush = 1'b0;
        check("s4_flush_valid",  {31'd0, bif.data_2_valid}, 32'd0);
        check("s4_flush_data",   {16'd0, bif.data_2},       32'hABCD);
        check("s4_flush_parity", {31'd0, bif.parity},       32'd0);
        for (int i = 0; i < 20 && !bif.data_2_valid; i++) tick();
        check("s4_next_data", {16'd0, bif.data_2},   32'h1234);
        check("s4_next_cnt",  {24'd0, bif.word_cnt}, 32'd5);

        // asynchronous reset mid-hold
        tick();
        tick();
        #3 rst = 1'b0;
        #1;
        check("s5_valid", {31'd0, bif.data_2_valid}, 32'd0);
        check("s5_data",  {16'd0, bif.data_2},       32'd0);
        check("s5_par",   {31'd0, bif.parity},       32'd0);
        check("s5_cnt",   {24'd0, bif.word_cnt},     32'd0);
        check("s5_rd_en", {31'd0, bif.rd_en},        32'd0);
        tick();
        #3 rst = 1'b1;
        clear_mon();
        for (int i = 0; i < 10; i++) tick();
        check("s5_no_rd", rd_pulses, 32'd0);

        // 257 words, prog=0: word_cnt wraps to 1
        bif.prog = 3'd0;
        clear_mon();
        for (int i = 0; i < 257; i++) push(16'(i));
        for (int i = 0; i < 2000 && v_runs < 257; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        check("s6_runs",      v_runs,     32'd257);
        check("s6_rd_pulses", rd_pulses,  32'd257);
        check("s6_rd_width",  rd_max_run, 32'd1);
        check("s6_gap_ge1",   {31'd0, (v_min_gap >= 1 && v_min_gap < 999)}, 32'd1);
        check("s6_data",      {16'd0, bif.data_2},   32'h0100);
        check("s6_cnt_wrap",  {24'd0, bif.word_cnt}, 32'd1);
        check("underflow",    underflow,  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 SHALL have port buf_empty  input  1  FIFO read-side empty flag.
REQ-004 SHALL have port buf_data  input  16  FIFO read data, valid the cycle after the edge that samples rd_en=1.
REQ-005 SHALL have port prog  input  3  dwell select: hold time = 2^prog cycles (1..128).
REQ-006 SHALL have port flush  input  1  level; discard words instead of presenting them.
REQ-007 SHALL have port rd_en  output  1  FIFO read strobe, registered.
REQ-008 SHALL have port data_2  output  16  presented word, registered.
REQ-009 SHALL have port data_2_valid  output  1  high while data_2 is being presented.
REQ-010 SHALL have port parity  output  1  even parity (XOR of all data_2 bits), registered with data_2.
REQ-011 SHALL have port word_cnt  output  8  count of presented words.

Function
REQ-012 SHALL implement FSM with states S_IDLE, S_REQ, S_LOAD, S_HOLD.
REQ-013 In S_IDLE, buf_empty=0 SHALL cause: next state S_REQ, rd_en<=1; buf_empty=1 SHALL keep S_IDLE with rd_en=0.
REQ-014 In S_REQ, the block SHALL set rd_en<=0 and go to S_LOAD unconditionally; rd_en SHALL be high for exactly one cycle per word.
REQ-015 In S_LOAD with flush=0, the block SHALL capture buf_data into data_2, set parity<=^buf_data, set data_2_valid<=1, load the dwell counter with 2^prog (prog sampled here only), increment word_cnt, and go to S_HOLD.
REQ-016 In S_LOAD with flush=1, the block SHALL leave data_2, parity, data_2_valid=0, and word_cnt unchanged, and return to S_IDLE (word discarded).
REQ-017 In S_HOLD, the block SHALL decrement the counter each cycle; data_2_valid SHALL stay high for exactly 2^prog cycles, then go low as state returns to S_IDLE.
REQ-018 A flush=1 sampled in S_HOLD SHALL clear data_2_valid and return to S_IDLE at that edge; data_2 and parity SHALL retain their last values.
REQ-019 Latency: the first edge sampling buf_empty=0 in S_IDLE to data_2_valid=1 SHALL be 3 edges; back-to-back period SHALL be 2^prog+3 cycles per word.
REQ-020 The block SHALL never assert rd_en unless buf_empty=0 was sampled in S_IDLE; buf_empty changes in S_REQ/S_LOAD/S_HOLD SHALL be ignored.
REQ-021 word_cnt SHALL wrap 255->0 without any flag.
REQ-022 data_2_valid SHALL be low for at least one cycle between consecutive presented words.
REQ-023 A prog change during S_HOLD SHALL NOT affect the current dwell.

Reset
REQ-024 On rst=0, immediately and regardless of state: state=S_IDLE, rd_en=0, data_2=16'h0000, data_2_valid=0, parity=0, word_cnt=0, dwell counter=0.
REQ-025 On rst release, the first action SHALL occur at the first rising edge with rst=1; a word read before reset SHALL be lost.

Verification
REQ-026 Scenario: prog=0, FIFO holds 16'h0001 -> rd_en one cycle, data_2=16'h0001, parity=1, data_2_valid high 1 cycle, word_cnt=1, 3 edges after buf_empty falls.
REQ-027 Scenario: prog=3, FIFO holds 16'h00FF, 16'h0003 -> each valid for exactly 8 cycles, gap of at least 1 cycle, rd_en pulses 11 cycles apart, parity=0 both, word_cnt=2.
REQ-028 Scenario: flush=1 with 4 words queued -> 4 single-cycle rd_en pulses, data_2_valid stays 0, data_2 and word_cnt unchanged.
REQ-029 Scenario: prog=7, word 16'hABCD presented, flush pulsed at hold cycle 10 -> data_2_valid falls at that edge, data_2 stays 16'hABCD, next word then read.
REQ-030 Scenario: rst=0 asserted mid-S_HOLD (asynchronously, between edges) -> all outputs zero immediately; after release with buf_empty=1 there is no rd_en pulse.
REQ-031 Scenario: 257 words with prog=0 -> word_cnt ends at 1 (wrap), with no rd_en ever asserted while buf_empty=1.
